// File: rtl/mem_wb_if.sv
// MEM -> WB bus: instruction fields captured from the MEM stage and the
// registered writeback / forwarding port seen by the register file and
// the hazard unit.
interface mem_wb_if #(
    parameter int DW = 32
);
    // MEM stage side
    logic          m_valid;
    logic [DW-1:0] m_pc;
    logic [DW-1:0] m_alu;
    logic [DW-1:0] m_ldata;
    logic [4:0]    m_rd;
    logic          m_regwen;
    logic [1:0]    m_wbsel;

    // WB side (register-file write port and forwarding source)
    logic          w_valid;
    logic [DW-1:0] w_pc;
    logic [4:0]    w_rd;
    logic          w_regwen;
    logic [DW-1:0] w_data;

    // Producer of MEM results, consumer of the WB port
    modport master (
        output m_valid, m_pc, m_alu, m_ldata, m_rd, m_regwen, m_wbsel,
        input  w_valid, w_pc, w_rd, w_regwen, w_data
    );

    // The pipeline register itself
    modport slave (
        input  m_valid, m_pc, m_alu, m_ldata, m_rd, m_regwen, m_wbsel,
        output w_valid, w_pc, w_rd, w_regwen, w_data
    );
endinterface

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register of the rv32i core. Selects the writeback value,
// registers it with the destination info one cycle late, and keeps the
// retired-instruction counter. No handshake: the pipeline controls it with
// stall (hold everything) and flush (kill the captured instruction); flush
// wins over stall. Every output comes straight from a flop.
module mem_wb_reg #(
    parameter int DW   = 32,
    parameter int CNTW = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            flush,
    mem_wb_if.slave         bus,
    output logic [CNTW-1:0] instret
);

    logic [DW-1:0] wb_value;
    logic          write_ok;

    // Writeback source select; the reserved code falls back to the ALU result
    always_comb begin
        wb_value = bus.m_alu;
        case (bus.m_wbsel)
            2'b01:   wb_value = bus.m_ldata;
            2'b10:   wb_value = bus.m_pc + DW'(4);
            default: wb_value = bus.m_alu;
        endcase
    end

    // Bubbles never write and x0 is never a write target
    assign write_ok = bus.m_valid & bus.m_regwen & (bus.m_rd != 5'd0);

    // WB register update: reset, then flush, then stall hold, then capture
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.w_valid  <= 1'b0;
            bus.w_pc     <= '0;
            bus.w_rd     <= 5'd0;
            bus.w_regwen <= 1'b0;
            bus.w_data   <= '0;
            instret      <= '0;
        end else if (flush) begin
            // pc/data are meaningless once valid drops, so they simply hold
            bus.w_valid  <= 1'b0;
            bus.w_rd     <= 5'd0;
            bus.w_regwen <= 1'b0;
        end else if (!stall) begin
            bus.w_valid  <= bus.m_valid;
            bus.w_pc     <= bus.m_pc;
            bus.w_rd     <= bus.m_rd;
            bus.w_regwen <= write_ok;
            bus.w_data   <= wb_value;
            // Counted on entry, so a stalled instruction is counted once
            if (bus.m_valid) begin
                instret <= instret + CNTW'(1);
            end
        end
    end

endmodule

// File: tb/tb_mem_wb_reg.sv
// Bench for mem_wb_reg: directed steps from the test plan plus a random
// section, with a reference model feeding an expected-result queue.
// A second instance with a 3-bit counter exercises instret wrap-around.
module tb_mem_wb_reg;

    localparam int DW = 32;

    typedef struct packed {
        logic          valid;
        logic [DW-1:0] pc;
        logic [4:0]    rd;
        logic          regwen;
        logic [DW-1:0] data;
        logic [63:0]   cnt;
    } wb_t;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        flush;
    logic [63:0] instret;
    logic [2:0]  instret_s;

    mem_wb_if #(.DW(DW)) bus ();
    mem_wb_if #(.DW(DW)) bus_s ();

    mem_wb_reg #(.DW(DW), .CNTW(64)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .bus(bus.slave), .instret(instret)
    );

    mem_wb_reg #(.DW(DW), .CNTW(3)) dut_s (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .bus(bus_s.slave), .instret(instret_s)
    );

    assign bus_s.m_valid  = bus.m_valid;
    assign bus_s.m_pc     = bus.m_pc;
    assign bus_s.m_alu    = bus.m_alu;
    assign bus_s.m_ldata  = bus.m_ldata;
    assign bus_s.m_rd     = bus.m_rd;
    assign bus_s.m_regwen = bus.m_regwen;
    assign bus_s.m_wbsel  = bus.m_wbsel;

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int  checks   = 0;
    int  failures = 0;
    wb_t exp_q[$];
    wb_t model;
    logic [63:0] saved_cnt;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_valid"},   {63'd0, bus.w_valid},  64'd0);
        check({tag, "_pc"},      {32'd0, bus.w_pc},     64'd0);
        check({tag, "_rd"},      {59'd0, bus.w_rd},     64'd0);
        check({tag, "_regwen"},  {63'd0, bus.w_regwen}, 64'd0);
        check({tag, "_data"},    {32'd0, bus.w_data},   64'd0);
        check({tag, "_instret"}, instret,               64'd0);
        check({tag, "_instret_s"}, {61'd0, instret_s},  64'd0);
    endtask

    // One clock step: drive MEM inputs, predict, clock, then compare
    task automatic step(input logic v, input logic [DW-1:0] pc, input logic [DW-1:0] alu,
                        input logic [DW-1:0] ld, input logic [4:0] rd, input logic rw,
                        input logic [1:0] sel, input logic st, input logic fl);
        wb_t got;
        wb_t exp;
        bus.m_valid  = v;
        bus.m_pc     = pc;
        bus.m_alu    = alu;
        bus.m_ldata  = ld;
        bus.m_rd     = rd;
        bus.m_regwen = rw;
        bus.m_wbsel  = sel;
        stall        = st;
        flush        = fl;
        if (fl) begin
            model.valid  = 1'b0;
            model.regwen = 1'b0;
            model.rd     = 5'd0;
        end else if (!st) begin
            model.valid  = v;
            model.pc     = pc;
            model.rd     = rd;
            model.regwen = v && rw && (rd != 5'd0);
            case (sel)
                2'b01:   model.data = ld;
                2'b10:   model.data = pc + 32'd4;
                default: model.data = alu;
            endcase
            if (v) model.cnt = model.cnt + 64'd1;
        end
        exp_q.push_back(model);
        @(posedge clk);
        #1;
        got.valid  = bus.w_valid;
        got.pc     = bus.w_pc;
        got.rd     = bus.w_rd;
        got.regwen = bus.w_regwen;
        got.data   = bus.w_data;
        got.cnt    = instret;
        exp = exp_q.pop_front();
        check("sb_valid",  {63'd0, got.valid},  {63'd0, exp.valid});
        check("sb_rd",     {59'd0, got.rd},     {59'd0, exp.rd});
        check("sb_regwen", {63'd0, got.regwen}, {63'd0, exp.regwen});
        if (exp.valid) begin
            check("sb_pc",   {32'd0, got.pc},   {32'd0, exp.pc});
            check("sb_data", {32'd0, got.data}, {32'd0, exp.data});
        end
        check("sb_instret",   got.cnt, exp.cnt);
        check("sb_instret_s", {61'd0, instret_s}, {61'd0, exp.cnt[2:0]});
    endtask

    task automatic model_reset();
        model = '0;
    endtask

    initial begin
        rst = 1'b0;
        stall = 1'b0;
        flush = 1'b0;
        bus.m_valid = 1'b0;
        bus.m_pc = '0;
        bus.m_alu = '0;
        bus.m_ldata = '0;
        bus.m_rd = '0;
        bus.m_regwen = 1'b0;
        bus.m_wbsel = 2'b00;
        model_reset();

        // reset state, including across an edge held in reset
        #2;
        check_zero_outputs("reset_init");
        @(posedge clk);
        #1;
        check_zero_outputs("reset_held");
        #3;
        rst = 1'b1;

        // ALU / load / link captures
        step(1'b1, 32'h0000_0040, 32'h1234_5678, 32'h0, 5'd5, 1'b1, 2'b00, 1'b0, 1'b0);
        check("alu_data",   {32'd0, bus.w_data}, 64'h1234_5678);
        check("alu_rd",     {59'd0, bus.w_rd},   64'd5);
        check("alu_regwen", {63'd0, bus.w_regwen}, 64'd1);
        step(1'b1, 32'h0000_0044, 32'h0000_1000, 32'hFFFF_FF80, 5'd6, 1'b1, 2'b01, 1'b0, 1'b0);
        check("load_data", {32'd0, bus.w_data}, 64'hFFFF_FF80);
        step(1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0, 5'd1, 1'b1, 2'b10, 1'b0, 1'b0);
        check("link_data", {32'd0, bus.w_data}, 64'h0000_0104);
        check("instret_3", instret, 64'd3);

        // reserved wbsel behaves as ALU
        step(1'b1, 32'h0000_0108, 32'h0BAD_F00D, 32'h1111_1111, 5'd9, 1'b1, 2'b11, 1'b0, 1'b0);
        check("wbsel11_data", {32'd0, bus.w_data}, 64'h0BAD_F00D);

        // x0 never written, bubble never written or counted
        step(1'b1, 32'h0000_010C, 32'h5555_5555, 32'h0, 5'd0, 1'b1, 2'b00, 1'b0, 1'b0);
        check("x0_regwen", {63'd0, bus.w_regwen}, 64'd0);
        check("x0_valid",  {63'd0, bus.w_valid},  64'd1);
        check("x0_instret", instret, 64'd5);
        step(1'b0, 32'h0000_0110, 32'h6666_6666, 32'h0, 5'd7, 1'b1, 2'b00, 1'b0, 1'b0);
        check("bubble_regwen", {63'd0, bus.w_regwen}, 64'd0);
        check("bubble_valid",  {63'd0, bus.w_valid},  64'd0);
        check("bubble_instret", instret, 64'd5);

        // stall hold for 4 cycles with changing inputs
        step(1'b1, 32'h0000_0200, 32'h0000_00AA, 32'h0, 5'd3, 1'b1, 2'b00, 1'b0, 1'b0);
        saved_cnt = model.cnt;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, $urandom, $urandom, $urandom, 5'($urandom_range(1, 31)), 1'b1,
                 2'($urandom_range(0, 3)), 1'b1, 1'b0);
            check("stall_rd",     {59'd0, bus.w_rd},     64'd3);
            check("stall_data",   {32'd0, bus.w_data},   64'h0000_00AA);
            check("stall_regwen", {63'd0, bus.w_regwen}, 64'd1);
            check("stall_instret", instret, saved_cnt);
        end

        // flush beats stall
        step(1'b1, 32'h0000_0300, 32'h0000_0077, 32'h0, 5'd4, 1'b1, 2'b00, 1'b1, 1'b1);
        check("flush_valid",   {63'd0, bus.w_valid},  64'd0);
        check("flush_regwen",  {63'd0, bus.w_regwen}, 64'd0);
        check("flush_rd",      {59'd0, bus.w_rd},     64'd0);
        check("flush_instret", instret, saved_cnt);

        // PC+4 wraps modulo 2^32
        step(1'b1, 32'hFFFF_FFFC, 32'h0, 32'h0, 5'd1, 1'b1, 2'b10, 1'b0, 1'b0);
        check("link_wrap_data", {32'd0, bus.w_data}, 64'd0);

        // random traffic; carries the 3-bit counter across its wrap
        for (int i = 0; i < 40; i++) begin
            step($urandom_range(0, 3) != 0, $urandom, $urandom, $urandom,
                 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                 2'($urandom_range(0, 3)),
                 $urandom_range(0, 4) == 0, $urandom_range(0, 7) == 0);
        end

        // explicit wrap on the narrow counter: step valid until it reads 7
        for (int i = 0; i < 8 && instret_s != 3'd7; i++) begin
            step(1'b1, 32'h400, 32'h1, 32'h0, 5'd2, 1'b1, 2'b00, 1'b0, 1'b0);
        end
        check("wrap_pre", {61'd0, instret_s}, 64'd7);
        step(1'b1, 32'h404, 32'h2, 32'h0, 5'd2, 1'b1, 2'b00, 1'b0, 1'b0);
        check("wrap_post", {61'd0, instret_s}, 64'd0);

        // asynchronous reset mid-cycle during a stall with a valid write
        step(1'b1, 32'h500, 32'h99, 32'h0, 5'd8, 1'b1, 2'b00, 1'b0, 1'b0);
        stall = 1'b1;
        #3;
        rst = 1'b0;
        #1;
        check_zero_outputs("reset_async");
        model_reset();
        @(posedge clk);
        #3;
        rst = 1'b1;
        stall = 1'b0;

        // capture resumes after reset release
        step(1'b1, 32'h600, 32'h0000_BEEF, 32'h0, 5'd10, 1'b1, 2'b00, 1'b0, 1'b0);
        check("after_reset_instret", instret, 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_wb_reg.md
Name: mem_wb_reg

Overview:
- Pipeline register between the MEM stage and the register-file write port of the rv32i core.
- Captures MEM results and selects the writeback value (ALU result, load data or PC+4).
- Presents a one-cycle-late write/forwarding port to the register file and the hazard unit.
- Maintains the retired-instruction counter (instret).

Parameters:
DW, 32, datapath width (pc, alu, load data, writeback data)
CNTW, 64, width of the instret counter

Ports:
clk  input  1  core clock; all state updates on rising edge
rst  input  1  asynchronous active-low reset
m_valid  input  1  MEM stage holds a real instruction (0 = bubble)
m_pc  input  DW  PC of the MEM instruction
m_alu  input  DW  ALU result / address from EX
m_ldata  input  DW  load data from MEM (already size/sign-extended)
m_rd  input  5  destination register index
m_regwen  input  1  instruction writes rd
m_wbsel  input  2  00 ALU, 01 load, 10 PC+4, 11 reserved (treated as ALU)
stall  input  1  hold current WB contents
flush  input  1  kill the instruction being captured
w_valid  output  1  WB holds a real instruction
w_pc  output  DW  PC of WB instruction
w_rd  output  5  register-file write index
w_regwen  output  1  register-file write enable (qualified)
w_data  output  DW  register-file write data / forwarding data
instret  output  CNTW  count of retired instructions

Behaviour:
- Reset (rst=0, asynchronous, no clock required):
  - w_valid=0, w_pc=0, w_rd=0, w_regwen=0, w_data=0, instret=0.
  - Outputs stay at these values while rst=0. The first capture happens on the first rising edge after rst rises.
- Writeback mux at capture:
  - wbsel 00 / 11: m_alu.
  - wbsel 01: m_ldata.
  - wbsel 10: m_pc+4, modulo 2^DW, so 0xFFFFFFFC gives 0x00000000.
  - The mux result is registered into w_data. Latency is 1 cycle from the MEM inputs to the w_* outputs.
- Per-edge update priority: flush > stall > normal capture.
  - flush=1: w_valid=0, w_regwen=0, w_rd=0. w_pc and w_data are don't-care (hold). instret unchanged. This holds even if stall=1.
  - stall=1, flush=0: every w_* register and instret hold their values.
  - Normal capture: w_valid=m_valid, w_pc=m_pc, w_rd=m_rd, w_data=mux result.
    - w_regwen=m_valid & m_regwen & (m_rd!=0).
    - x0 is never written. A bubble never writes, regardless of m_regwen.
- w_regwen is purely registered. No combinational path from any input to any output.
- instret:
  - Increments by 1 on each normal-capture edge with m_valid=1. A held instruction is counted once.
  - Bubbles and flushed instructions are not counted.
  - Wraps from 2^CNTW-1 to 0 with no flag.
- Stalled instruction: keeps w_regwen asserted for every stalled cycle. The repeated write of the same value is legal.
- Reset asserted mid-stall or mid-flush: reset wins immediately and all outputs clear.
- Forwarding: the hazard unit uses (w_regwen, w_rd, w_data) as the WB forwarding source. No separate port.

Test Plan:
- Reset: drive rst=0 asynchronously mid-cycle with WB holding a valid write -> all outputs 0 before the next edge. instret=0.
- ALU/load/link capture: three consecutive edges, each with m_valid=1, m_regwen=1.
  - Edge 1: wbsel=00, m_alu=0x12345678, m_rd=5 -> next cycle w_data=0x12345678, w_rd=5, w_regwen=1.
  - Edge 2: wbsel=01, m_ldata=0xFFFFFF80 -> w_data=0xFFFFFF80.
  - Edge 3: wbsel=10, m_pc=0x00000100 -> w_data=0x00000104.
  - Result: instret=3.
- x0 and bubble: m_rd=0, m_regwen=1, m_valid=1 -> w_regwen=0, w_valid=1, instret+1. Then m_valid=0, m_regwen=1, m_rd=7 -> w_regwen=0, w_valid=0, instret unchanged.
- Stall hold: capture rd=3, data 0xAA. Hold stall=1 for 4 cycles while inputs change -> w_rd=3, w_data=0xAA, w_regwen=1 throughout. instret increments exactly once.
- Flush priority: stall=1 and flush=1 together on a valid WB instruction -> next cycle w_valid=0, w_regwen=0, w_rd=0, instret unchanged.
- Wrap: force instret to 0xFFFFFFFFFFFFFFFF, capture a valid instruction -> instret=0. Also m_pc=0xFFFFFFFC with wbsel=10 -> w_data=0x00000000.
